neuron_mem_arbiter: RTL and testbench

- Shares the single-port neuron-state SRAM between two requesters: the controller FSM's time-multiplexed neuron update sequence (core port) and the OBI bus slave used for neuron-state readback/initialisation.
- Protects read-modify-write pairs from the core against interleaved bus accesses.
- Bounds bus starvation during long neuron sweeps.
- Sits between the controller/neuron-core and the neuron SRAM macro.

---
 rtl/neuron_mem_arb_pkg.sv | 21 ++
 rtl/neuron_mem_arbiter_starve_cnt.sv | 35 +++
 rtl/neuron_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_neuron_mem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_mem_arb_pkg.sv
// rtl/neuron_mem_arb_pkg.sv - shared types and address helpers for the neuron SRAM arbiter
package neuron_mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_CORE_RD = 2'd1,
    OWN_OBI     = 2'd2
  } owner_e;

  function automatic logic [31:0] stats_addr(input int unsigned n);
    return n << 2;
  endfunction

  localparam logic [31:0] STATS_ADDR = stats_addr(256);

  // Word index below the SRAM depth; byte lane bits are ignored.
  function automatic logic obi_in_range(input logic [31:0] addr, input int unsigned n);
    return {2'b00, addr[31:2]} < n;
  endfunction

endpackage

// File: rtl/neuron_mem_arbiter_starve_cnt.sv
// rtl/neuron_mem_arbiter_starve_cnt.sv - saturating count of core grants made while OBI waits
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int W = $clog2(STARVE_MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(STARVE_MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == W'(STARVE_MAX));

endmodule

// File: rtl/neuron_mem_arbiter.sv
// rtl/neuron_mem_arbiter.sv - neuron SRAM arbiter (core vs OBI); NEURON_MEM_ARBITER_STATS_EN adds stall counter
module neuron_mem_arbiter
  import neuron_mem_arb_pkg::*;
#(
  parameter int N          = 256,
  parameter int M          = 8,
  parameter int NEUR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic              core_lock_i,
  input  logic [M-1:0]      core_addr_i,
  input  logic [NEUR_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [NEUR_W-1:0] core_rdata_o,
  input  logic              obi_req_i,
  input  logic              obi_we_i,
  input  logic [31:0]       obi_addr_i,
  input  logic [31:0]       obi_wdata_i,
  output logic              obi_gnt_o,
  output logic              obi_rvalid_o,
  output logic [31:0]       obi_rdata_o,
  output logic              sram_cs_o,
  output logic              sram_we_o,
  output logic [M-1:0]      sram_addr_o,
  output logic [NEUR_W-1:0] sram_wdata_o,
  input  logic [NEUR_W-1:0] sram_rdata_i,
  output logic              obi_stall_o
);

  owner_e owner_q;
  logic   lock_q;
  logic   obi_rd_q;
  logic   at_max;
  logic   in_range;
  logic   obi_sram;
  logic   addr_lsb_unused;
  logic   stats_word;

  assign addr_lsb_unused = ^obi_addr_i[1:0];
  assign in_range        = obi_in_range(obi_addr_i, N);

  // Grants are held low while in reset so every output reads 0.
  assign obi_gnt_o   = RSTN & ~lock_q & obi_req_i & (at_max | ~core_req_i);
  assign core_gnt_o  = RSTN & core_req_i & ~obi_gnt_o;
  assign obi_stall_o = RSTN & obi_req_i & ~obi_gnt_o;
  assign obi_sram    = obi_gnt_o & in_range;

  assign sram_cs_o    = core_gnt_o | obi_sram;
  assign sram_we_o    = core_gnt_o ? core_we_i : (obi_sram & obi_we_i);
  assign sram_addr_o  = core_gnt_o ? core_addr_i :
                        (obi_sram ? obi_addr_i[M+1:2] : '0);
  assign sram_wdata_o = core_gnt_o ? core_wdata_i :
                        (obi_sram ? obi_wdata_i[NEUR_W-1:0] : '0);

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .inc_i   (core_gnt_o & obi_req_i),
    .clr_i   (obi_gnt_o | ~obi_req_i),
    .at_max_o(at_max)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      owner_q  <= OWN_NONE;
      lock_q   <= 1'b0;
      obi_rd_q <= 1'b0;
    end else begin
      lock_q   <= core_gnt_o & ~core_we_i & core_lock_i;
      obi_rd_q <= obi_sram & ~obi_we_i;
      if (core_gnt_o && !core_we_i) begin
        owner_q <= OWN_CORE_RD;
      end else if (obi_gnt_o) begin
        owner_q <= OWN_OBI;
      end else begin
        owner_q <= OWN_NONE;
      end
    end
  end

  assign core_rvalid_o = (owner_q == OWN_CORE_RD);
  assign core_rdata_o  = core_rvalid_o ? sram_rdata_i : '0;
  assign obi_rvalid_o  = (owner_q == OWN_OBI);

`ifdef NEURON_MEM_ARBITER_STATS_EN
  localparam logic [31:0] STATS_BYTE = stats_addr(N);

  logic [15:0] stall_cnt_q;
  logic [15:0] stat_val_q;
  logic        stat_rd_q;

  assign stats_word = (obi_addr_i[31:2] == STATS_BYTE[31:2]);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      stall_cnt_q <= '0;
      stat_val_q  <= '0;
      stat_rd_q   <= 1'b0;
    end else begin
      stat_rd_q  <= obi_gnt_o & stats_word & ~obi_we_i;
      stat_val_q <= stall_cnt_q;
      if (obi_gnt_o && stats_word && obi_we_i) begin
        stall_cnt_q <= '0;
      end else if (obi_stall_o && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign obi_rdata_o = !obi_rvalid_o ? 32'd0 :
                       obi_rd_q      ? 32'(sram_rdata_i) :
                       stat_rd_q     ? {16'd0, stat_val_q} : 32'd0;
`else
  assign stats_word  = 1'b0;
  assign obi_rdata_o = (obi_rvalid_o && obi_rd_q) ? 32'(sram_rdata_i) : 32'd0;
`endif

  logic stats_word_unused;
  assign stats_word_unused = stats_word;

endmodule

// File: tb/tb_neuron_mem_arbiter.sv
// tb/tb_neuron_mem_arbiter.sv - scoreboard bench for neuron_mem_arbiter with a 1-cycle SRAM model
module tb_neuron_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        core_req_i = 0, core_we_i = 0, core_lock_i = 0;
  logic [7:0]  core_addr_i = 0;
  logic [31:0] core_wdata_i = 0;
  logic        core_gnt_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        obi_req_i = 0, obi_we_i = 0;
  logic [31:0] obi_addr_i = 0, obi_wdata_i = 0;
  logic        obi_gnt_o, obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        sram_cs_o, sram_we_o;
  logic [7:0]  sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata_i = 0;
  logic        obi_stall_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] core_q[$];
  logic [31:0] obi_q[$];
  logic [31:0] mem [256];
  logic [31:0] exp_c, exp_o;

`ifdef NEURON_MEM_ARBITER_STATS_EN
  localparam logic [31:0] STATS_EXP = 32'd6;
`else
  localparam logic [31:0] STATS_EXP = 32'd0;
`endif

  always #5 CLK = ~CLK;

  neuron_mem_arbiter dut (
    .CLK(CLK), .RSTN(RSTN),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_lock_i(core_lock_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .obi_req_i(obi_req_i), .obi_we_i(obi_we_i), .obi_addr_i(obi_addr_i),
    .obi_wdata_i(obi_wdata_i), .obi_gnt_o(obi_gnt_o), .obi_rvalid_o(obi_rvalid_o),
    .obi_rdata_o(obi_rdata_o), .sram_cs_o(sram_cs_o), .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
    .obi_stall_o(obi_stall_o)
  );

  always @(posedge CLK) begin
    if (sram_cs_o) begin
      if (sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
      else           sram_rdata_i <= mem[sram_addr_o];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge CLK) begin
    if (core_rvalid_o) begin
      if (core_q.size() == 0) check("core_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        exp_c = core_q.pop_front();
        check("core_rdata", core_rdata_o, exp_c);
      end
    end else check("core_rdata_idle", core_rdata_o, 32'd0);
    if (obi_rvalid_o) begin
      if (obi_q.size() == 0) check("obi_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        exp_o = obi_q.pop_front();
        check("obi_rdata", obi_rdata_o, exp_o);
      end
    end else check("obi_rdata_idle", obi_rdata_o, 32'd0);
  end

  task automatic set_core(input logic req, input logic we, input logic lock,
                          input logic [7:0] addr, input logic [31:0] wd);
    core_req_i = req; core_we_i = we; core_lock_i = lock;
    core_addr_i = addr; core_wdata_i = wd;
  endtask

  task automatic set_obi(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
    obi_req_i = req; obi_we_i = we; obi_addr_i = addr; obi_wdata_i = wd;
  endtask

  task automatic tick(input logic ec, input logic eo, input int ecs, input string nm);
    @(negedge CLK);
    check({nm, "_core_gnt"}, core_gnt_o, ec);
    check({nm, "_obi_gnt"}, obi_gnt_o, eo);
    check({nm, "_stall"}, obi_stall_o, obi_req_i & ~eo);
    if (ecs >= 0) check({nm, "_sram_cs"}, sram_cs_o, ecs[0]);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_ctl"}, {25'd0, core_gnt_o, core_rvalid_o, obi_gnt_o, obi_rvalid_o,
                         sram_cs_o, sram_we_o, obi_stall_o}, 32'd0);
    check({nm, "_core_rdata"}, core_rdata_o, 32'd0);
    check({nm, "_obi_rdata"}, obi_rdata_o, 32'd0);
    check({nm, "_sram_addr"}, {24'd0, sram_addr_o}, 32'd0);
    check({nm, "_sram_wdata"}, sram_wdata_o, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h0BADF00D;
    mem[5] = 32'hDEADBEEF;
    mem[8] = 32'hA5A50008;

    @(posedge CLK); @(negedge CLK);
    check_outputs_zero("reset");
    @(posedge CLK); #1;
    RSTN = 1'b1;

    // Plain core read.
    set_core(1, 0, 0, 8'h05, 0);
    core_q.push_back(32'hDEADBEEF);
    tick(1, 0, 1, "rd");
    set_core(0, 0, 0, 0, 0);
    tick(0, 0, 0, "rd_idle");

    // Locked read-modify-write keeps OBI out for two cycles.
    set_obi(1, 0, 32'h14, 0);
    set_core(1, 0, 1, 8'h05, 0);
    core_q.push_back(32'hDEADBEEF);
    tick(1, 0, 1, "rmw_rd");
    set_core(1, 1, 0, 8'h05, 32'h12345678);
    tick(1, 0, 1, "rmw_wr");
    set_core(0, 0, 0, 0, 0);
    obi_q.push_back(32'h12345678);
    tick(0, 1, 1, "rmw_obi");
    set_obi(0, 0, 0, 0);
    tick(0, 0, 0, "rmw_idle");

    // Starvation bound: four core grants then OBI.
    set_core(1, 0, 0, 8'h05, 0);
    set_obi(1, 0, 32'h20, 0);
    for (int i = 0; i < 4; i++) begin
      core_q.push_back(32'h12345678);
      tick(1, 0, 1, "starve_core");
    end
    obi_q.push_back(32'hA5A50008);
    tick(0, 1, 1, "starve_obi");
    set_obi(0, 0, 0, 0);
    core_q.push_back(32'h12345678);
    tick(1, 0, 1, "starve_resume");
    set_obi(1, 0, 32'h20, 0);
    core_q.push_back(32'h12345678);
    tick(1, 0, 1, "starve_recount");
    set_core(0, 0, 0, 0, 0);
    obi_q.push_back(32'hA5A50008);
    tick(0, 1, 1, "starve_obi2");
    set_obi(0, 0, 0, 0);

    // Out-of-range write is answered but never reaches the SRAM.
    set_obi(1, 1, 32'h2000, 32'hFFFFFFFF);
    obi_q.push_back(32'h0);
    tick(0, 1, 0, "oor_wr");
    set_obi(1, 0, 32'h0, 0);
    obi_q.push_back(32'h0BADF00D);
    tick(0, 1, 1, "oor_chk");
    set_obi(1, 0, 32'h2001, 0);
    obi_q.push_back(32'h0);
    tick(0, 1, 0, "oor_rd");
    set_obi(0, 0, 0, 0);
    tick(0, 0, 0, "oor_idle");

    // Stall statistics: clear, stall six cycles under lock, read back.
    set_obi(1, 1, 32'h400, 0);
    obi_q.push_back(32'h0);
    tick(0, 1, 0, "st_clr");
    set_obi(1, 0, 32'h400, 0);
    for (int i = 0; i < 5; i++) begin
      set_core(1, 0, 1, 8'h05, 0);
      core_q.push_back(32'h12345678);
      tick(1, 0, 1, "st_lock");
    end
    set_core(1, 0, 0, 8'h05, 0);
    core_q.push_back(32'h12345678);
    tick(1, 0, 1, "st_last_lock");
    obi_q.push_back(STATS_EXP);
    tick(0, 1, 0, "st_rd");
    set_core(0, 0, 0, 0, 0);
    set_obi(1, 1, 32'h400, 0);
    obi_q.push_back(32'h0);
    tick(0, 1, 0, "st_wr");
    set_obi(1, 0, 32'h400, 0);
    obi_q.push_back(32'h0);
    tick(0, 1, 0, "st_rd0");
    set_obi(0, 0, 0, 0);
    tick(0, 0, 0, "st_idle");

    // Reset right after a granted core read drops its response.
    set_core(1, 0, 0, 8'h05, 0);
    tick(1, 0, 1, "rst_rd");
    set_core(0, 0, 0, 0, 0);
    RSTN = 1'b0;
    @(negedge CLK);
    check_outputs_zero("rst_mid");
    @(posedge CLK); #1;
    RSTN = 1'b1;
    set_obi(1, 0, 32'h14, 0);
    obi_q.push_back(32'h12345678);
    tick(0, 1, 1, "rst_obi");
    set_obi(0, 0, 0, 0);
    tick(0, 0, 0, "drain0");
    tick(0, 0, 0, "drain1");

    check("core_q_empty", core_q.size(), 32'd0);
    check("obi_q_empty", obi_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
